ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative radix-2 divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions. It sits in the EX stage beside the combinational ALU. Its RESULT is muxed with the ALU RESULT into the EX/MEM pipeline register. While BUSY is high, the hazard unit stalls IF/ID/EX. The unit takes 32 or more cycles per operation, so the ALU no longer needs a single-cycle divider.

## Interface
- DATA_WIDTH, 32: operand and result width. Iteration count equals DATA_WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low. Assertion clears all state immediately.
- START  in  1  request pulse. Sampled only in IDLE.
- DIVOP  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Captured with START.
- DATA1  in  DATA_WIDTH  dividend, rs1. Captured with START.
- DATA2  in  DATA_WIDTH  divisor, rs2. Captured with START.
- FLUSH  in  1  synchronous abort, from branch mispredict or pipeline flush.
- BUSY  out  1  high while in CALC; drives the pipeline stall.
- DONE  out  1  one-cycle pulse; RESULT is valid during this cycle.
- RESULT  out  DATA_WIDTH  quotient or remainder. Holds its value until the next accepted START or reset.

## Operation
- States: IDLE, CALC, FIN.
- IDLE:
  - START=1 and FLUSH=0: capture DIVOP and operands, then go to CALC.
  - Divide-by-zero or signed overflow at capture: go straight to FIN.
- Operand preparation at capture:
  - DIV/REM: convert operands to magnitudes (two's-complement negate if MSB set).
  - Record qneg = A[MSB] XOR B[MSB] and rneg = A[MSB].
  - DIVU/REMU: use operands unchanged; qneg = rneg = 0.
- CALC, restoring algorithm, one quotient bit per cycle for DATA_WIDTH cycles:
  - Form trial = {rem[W-2:0], dvd[MSB]} - divisor, computed to W+1 bits.
  - Shift dvd left.
  - If trial is non-negative: rem = trial and the quotient LSB is 1. Otherwise rem = shifted value and the LSB is 0.
  - An iteration counter runs 0..W-1. After count W-1, go to FIN.
- FIN (one cycle):
  - DONE=1, BUSY=0.
  - RESULT = (qneg ? -quot : quot) for DIV/DIVU, or (rneg ? -rem : rem) for REM/REMU.
  - Next state is IDLE.
- Special cases (RV32M semantics, no trap):
  - Divisor 0: quotient = all ones; remainder = DATA1.
  - DIV/REM with DATA1 = 0x80000000 and DATA2 = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- START while in CALC or FIN is ignored. The caller must hold the stall and re-issue nothing.
- FLUSH=1 in any state: next state is IDLE with no DONE, and RESULT is unchanged.
  - FLUSH and START in the same IDLE cycle: FLUSH wins and nothing is captured.
- Arithmetic is modulo 2^DATA_WIDTH. No widening beyond W+1 bits for the trial subtract.

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0, state IDLE, counter 0, all internal registers 0.
- Reset mid-operation (asserted in CALC): BUSY=0 asynchronously. No DONE follows reset release.
- START accepted at edge k, normal case:
  - BUSY=1 from after edge k through edge k+W (that is, W cycles).
  - DONE=1 and RESULT valid in the cycle after edge k+W. For W=32, DONE is high in the 33rd cycle after START.
- START accepted at edge k, special case: BUSY stays 0 and DONE=1 in the cycle after edge k.
- Back-to-back: a new START is accepted in the IDLE cycle right after FIN. Minimum issue interval is W+2 cycles.
- DONE is exactly one cycle wide and never overlaps BUSY=1.
- Outputs are registered; there is no combinational path from the inputs to BUSY, DONE or RESULT.

## Test plan
- DIVU then REMU, 100 / 7: RESULT=14 with DONE in cycle 33 after START, then RESULT=2. BUSY high for exactly 32 cycles.
- DIV then REM, 0xFFFFFFF9 (-7) / 2: RESULT=0xFFFFFFFD (-3), then RESULT=0xFFFFFFFF (-1). Also 7 / -2: RESULT=0xFFFFFFFD, then remainder 1.
- DIV 5 / 0: RESULT=0xFFFFFFFF; REMU 5 / 0: RESULT=5. DONE one cycle after START and BUSY never high.
- DIV 0x80000000 / 0xFFFFFFFF: RESULT=0x80000000; REM of the same operands: RESULT=0. DONE one cycle after START.
- FLUSH and START interaction:
  - Start DIVU 1000/10, then FLUSH in CALC cycle 10: BUSY=0 next cycle, no DONE, RESULT keeps its previous value.
  - A START pulsed during CALC of a fresh op is ignored: the first op result is 100.
  - FLUSH and START in the same IDLE cycle: nothing is captured.
- Reset: assert RESET low in CALC cycle 5 of DIV 0x12345678 / 3. BUSY, DONE and RESULT read 0 immediately. After release, a new DIVU 9/3 returns 3 normally.

Source files
------------

// File: rtl/ex_div_unit_if.sv
// Handshake and data bundle between the EX-stage control and the iterative divider.
// The master issues requests and watches for completion; the slave is the divider itself.
interface ex_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            divop;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, divop, data1, data2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, divop, data1, data2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It works on operand magnitudes, produces one quotient bit per cycle and fixes the signs in the last step.
module ex_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  ex_div_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dsr_q, dsr_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           isSigned, isRem, aNeg, bNeg, divZero, overflow, trialNeg;
  logic [W-1:0]   aMag, bMag;
  logic [W:0]     trial;

  function automatic logic [W-1:0] finalize(input logic [1:0] op, input logic qn,
                                            input logic rn, input logic [W-1:0] q,
                                            input logic [W-1:0] r);
    if (op[1]) return rn ? -r : r;
    return qn ? -q : q;
  endfunction

  assign isSigned = ~bus.divop[0];
  assign isRem    = bus.divop[1];
  assign aNeg     = isSigned & bus.data1[W-1];
  assign bNeg     = isSigned & bus.data2[W-1];
  assign aMag     = aNeg ? -bus.data1 : bus.data1;
  assign bMag     = bNeg ? -bus.data2 : bus.data2;
  assign divZero  = (bus.data2 == '0);
  assign overflow = isSigned && (bus.data1 == {1'b1, {(W-1){1'b0}}}) && (bus.data2 == '1);

  // The full remainder takes part in the W+1 bit trial, so its sign bit is a clean borrow.
  assign trial    = {rem_q, dvd_q[W-1]} - {1'b0, dsr_q};
  assign trialNeg = trial[W];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.divop;
          cnt_d = '0;
          if (divZero) begin
            result_d = isRem ? bus.data1 : '1;
            state_d  = FIN;
          end else if (overflow) begin
            result_d = isRem ? '0 : bus.data1;
            state_d  = FIN;
          end else begin
            dvd_d   = aMag;
            dsr_d   = bMag;
            rem_d   = '0;
            quot_d  = '0;
            qneg_d  = aNeg ^ bNeg;
            rneg_d  = aNeg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d  = dvd_q << 1;
        rem_d  = trialNeg ? {rem_q[W-2:0], dvd_q[W-1]} : trial[W-1:0];
        quot_d = {quot_q[W-2:0], ~trialNeg};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          result_d = finalize(op_q, qneg_q, rneg_q, quot_d, rem_d);
          state_d  = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An abort never publishes a result, whether it hits a capture or the final iteration.
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == FIN);
  assign bus.result = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: directed RV32M cases plus random traffic checked against a
// cycle-timeline model built from plain signed/unsigned division.
module tb_ex_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_div_unit_if #(.DATA_WIDTH(W)) bus();

  ex_div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int nVec = 0;
  int nFail = 0;
  bit checkEn = 1'b0;

  // Model: "left" counts the edges until the unit is idle again after an accepted request.
  int left = 0;
  logic [W-1:0] expResult = '0;
  logic [W-1:0] opRes = '0;

  function automatic logic [W-1:0] refDiv(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic ovf;
    ovf = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   if (b == 0) return '1; else if (ovf) return a; else return $signed(a) / $signed(b);
      2'b01:   if (b == 0) return '1; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return '0; else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    return (b == 0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = 0;
      expResult = '0;
    end else if (bus.flush) begin
      left = 0;
    end else if (left == 0) begin
      if (bus.start) begin
        opRes = refDiv(bus.divop, bus.data1, bus.data2);
        if (isSpecial(bus.divop, bus.data1, bus.data2)) begin
          left = 1;
          expResult = opRes;
        end else begin
          left = W + 1;
        end
      end
    end else begin
      left = left - 1;
      if (left == 1) expResult = opRes;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model busy", W'(bus.busy), W'(left >= 2));
      checkOutput("model done", W'(bus.done), W'(left == 1));
      checkOutput("model result", bus.result, expResult);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.divop = op;
    bus.data1 = a;
    bus.data2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output logic [W-1:0] res, output int cycles, output int busyCnt);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    busyCnt = 0;
    res = '0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        seen = 1'b1;
        res = bus.result;
      end
    end
    if (!seen) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL done timeout: got no DONE in %0d cycles, want DONE", cycles);
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expRes, input int expCycles);
    logic [W-1:0] res;
    int cycles, busyCnt;
    applyStimulus(op, a, b);
    waitDone(res, cycles, busyCnt);
    checkOutput(name, res, expRes);
    checkOutput({name, " latency"}, W'(cycles), W'(expCycles));
    checkOutput({name, " busy cycles"}, W'(busyCnt), W'(expCycles > 1 ? W : 0));
  endtask

  task automatic watchIdle(input string name, input int n, input logic [W-1:0] keep);
    bit sawDone, sawBusy;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
      if (bus.busy) sawBusy = 1'b1;
    end
    checkOutput({name, " no done"}, W'(sawDone), '0);
    checkOutput({name, " no busy"}, W'(sawBusy), '0);
    checkOutput({name, " result kept"}, bus.result, keep);
  endtask

  task automatic randOperands(output logic [1:0] op, output logic [W-1:0] a, output logic [W-1:0] b);
    int sel;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: b = '0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
      3: b = $urandom_range(1, 7) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, want completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] res, a, b;
    logic [1:0] op;
    int cycles, busyCnt;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.divop = 2'b00;
    bus.data1 = '0;
    bus.data2 = '0;

    #2 rst_n = 1'b0;
    #20;
    checkOutput("reset busy", W'(bus.busy), '0);
    checkOutput("reset done", W'(bus.done), '0);
    checkOutput("reset result", bus.result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkEn = 1'b1;

    runOp("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    runOp("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    runOp("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    runOp("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    runOp("DIV 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1);

    // Abort in the tenth CALC cycle; the previous result (5) must survive.
    applyStimulus(2'b01, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checkOutput("flush busy drop", W'(bus.busy), '0);
    watchIdle("flush", 40, 32'd5);

    runOp("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // A second request while busy must be dropped.
    applyStimulus(2'b01, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data1 = 32'd7;
    bus.data2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone(res, cycles, busyCnt);
    checkOutput("ignored start", res, 32'd100);
    watchIdle("after ignored start", 40, 32'd100);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.divop = 2'b01;
    bus.data1 = 32'd50;
    bus.data2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    watchIdle("flush+start", 40, 32'd100);

    applyStimulus(2'b00, 32'h1234_5678, 32'd3);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", W'(bus.busy), '0);
    checkOutput("mid reset done", W'(bus.done), '0);
    checkOutput("mid reset result", bus.result, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    watchIdle("after reset", 40, '0);
    runOp("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back random requests, each issued in the IDLE cycle right after DONE.
    for (int i = 0; i < 150; i++) begin
      randOperands(op, a, b);
      runOp("random op", op, a, b, refDiv(op, a, b), isSpecial(op, a, b) ? 1 : 33);
    end

    // Free-running traffic with random START/FLUSH; only the model compare checks here.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      randOperands(op, a, b);
      bus.divop = op;
      bus.data1 = a;
      bus.data2 = b;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
